// File: rtl/conv_pkg.sv
// Shared constants for the CONV post-processing stages: memory select codes,
// FSM state codes and default data/image geometry.
package conv_pkg;

  localparam int DW_DEF    = 20;
  localparam int IMG_W_DEF = 64;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE = 4'd0;
  localparam state_t S_RD0  = 4'd1;
  localparam state_t S_RD1  = 4'd2;
  localparam state_t S_RD2  = 4'd3;
  localparam state_t S_RD3  = 4'd4;
  localparam state_t S_CAP  = 4'd5;
  localparam state_t S_WL1  = 4'd6;
  localparam state_t S_WL2  = 4'd7;
  localparam state_t S_DONE = 4'd8;

endpackage

// File: rtl/conv_pool_flatten_if.sv
// Shared result-memory port used by the pooling/flatten stage.
// Read: crd high for one cycle with csel/caddr_rd; cdata_rd is valid at the
// rising edge that ends that cycle. Write: cwr high for one cycle with
// csel/caddr_wr/cdata_wr, sampled on the rising edge. crd and cwr never overlap.
interface conv_pool_flatten_if #(
  parameter int AW = 12,
  parameter int DW = 20
);
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  modport master (
    output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  modport slave (
    input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    output cdata_rd
  );
endinterface

// File: rtl/pool_addr_gen.sv
// Window/quadrant counters for 2x2 stride-2 pooling; derives the layer-0 read
// address and the layer-1 / layer-2 write indices from the counter state.
module pool_addr_gen #(
  parameter int IMG_W = 64,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          q_inc,
  input  logic          win_inc,
  output logic          k,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] l1_idx,
  output logic [AW-1:0] l2_idx,
  output logic          last_win
);

  localparam int CW = $clog2(IMG_W) - 1;
  localparam logic [2*CW:0] WIN_ONE = 1;

  // win = {k, r, c}: the i wrap from last index to 0 carries straight into k
  logic [2*CW:0]   win;
  logic [1:0]      q;
  logic [CW-1:0]   r;
  logic [CW-1:0]   c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win <= '0;
      q   <= '0;
    end else if (clr) begin
      win <= '0;
      q   <= '0;
    end else begin
      if (q_inc)   q   <= q + 2'd1;
      if (win_inc) win <= win + WIN_ONE;
    end
  end

  assign k        = win[2*CW];
  assign r        = win[2*CW-1:CW];
  assign c        = win[CW-1:0];
  assign rd_addr  = AW'({r, q[1], c, q[0]});
  assign l1_idx   = AW'(win[2*CW-1:0]);
  assign l2_idx   = AW'({win[2*CW-1:0], win[2*CW]});
  assign last_win = &win;

endmodule

// File: rtl/conv_pool_flatten.sv
// 2x2 max-pool of both layer-0 maps into layer-1, optionally also writing the
// kernel-interleaved layer-2 flatten vector when CONV_FLATTEN_EN is defined.
module conv_pool_flatten
  import conv_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int AW    = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  conv_pool_flatten_if.master mem,
  output state_t              state_dbg
);

  state_t        state;
  state_t        state_nxt;
  logic          cnt_clr;
  logic          q_inc;
  logic          win_inc;
  logic          k;
  logic          last_win;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] l1_idx;
  logic [AW-1:0] l2_idx;
  logic          rd_first;
  logic [DW-1:0] max_q;

  pool_addr_gen #(.IMG_W(IMG_W), .AW(AW)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .q_inc    (q_inc),
    .win_inc  (win_inc),
    .k        (k),
    .rd_addr  (rd_addr),
    .l1_idx   (l1_idx),
    .l2_idx   (l2_idx),
    .last_win (last_win)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    q_inc     = 1'b0;
    win_inc   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_RD0;
        cnt_clr   = 1'b1;
      end
      S_RD0: begin state_nxt = S_RD1; q_inc = 1'b1; end
      S_RD1: begin state_nxt = S_RD2; q_inc = 1'b1; end
      S_RD2: begin state_nxt = S_RD3; q_inc = 1'b1; end
      S_RD3: begin state_nxt = S_CAP; q_inc = 1'b1; end
      S_CAP: state_nxt = S_WL1;
`ifdef CONV_FLATTEN_EN
      S_WL1: state_nxt = S_WL2;
      S_WL2: begin
        win_inc   = 1'b1;
        state_nxt = last_win ? S_DONE : S_RD0;
      end
`else
      S_WL1: begin
        win_inc   = 1'b1;
        state_nxt = last_win ? S_DONE : S_RD0;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the memory sees each
  // phase one cycle after the FSM enters it; the read data for a visible crd
  // cycle is captured on the edge that ends it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem.crd      <= 1'b0;
      mem.cwr      <= 1'b0;
      mem.csel     <= CSEL_NONE;
      mem.caddr_rd <= '0;
      mem.caddr_wr <= '0;
      mem.cdata_wr <= '0;
      rd_first     <= 1'b0;
      max_q        <= '0;
    end else begin
      state    <= state_nxt;
      done     <= (state == S_DONE);
      rd_first <= (state == S_RD0);
      mem.crd  <= (state >= S_RD0) && (state <= S_RD3);
      mem.cwr  <= (state == S_WL1) || (state == S_WL2);

      if (state == S_IDLE && start) busy <= 1'b1;
      else if (state == S_DONE)     busy <= 1'b0;

      if (state >= S_RD0 && state <= S_RD3) begin
        mem.caddr_rd <= rd_addr;
        mem.csel     <= k ? CSEL_L0K1 : CSEL_L0K0;
      end else if (state == S_WL1) begin
        mem.caddr_wr <= l1_idx;
        mem.cdata_wr <= max_q;
        mem.csel     <= k ? CSEL_L1K1 : CSEL_L1K0;
      end else if (state == S_WL2) begin
        mem.caddr_wr <= l2_idx;
        mem.csel     <= CSEL_L2;
      end

      // first quadrant loads outright; unsigned compare since data is post-ReLU
      if (mem.crd && (rd_first || mem.cdata_rd > max_q)) max_q <= mem.cdata_rd;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_conv_pool_flatten.sv
// Bench for conv_pool_flatten: directed table vectors, random maps against a
// pooling reference model, busy/done timing, ignored restart and mid-run reset.
module tb_conv_pool_flatten;
  import conv_pkg::*;

  localparam int DW = 20;
  localparam int AW = 12;
`ifdef CONV_FLATTEN_EN
  localparam int P  = 7;
  localparam int NV = 10;
`else
  localparam int P  = 6;
  localparam int NV = 8;
`endif
  localparam int BUSY_EXP = 2048 * P + 1;
  localparam logic [DW-1:0] SENT = 20'hABCDE;

  logic   clk = 1'b0;
  logic   reset;
  logic   start;
  logic   busy;
  logic   done;
  state_t state_dbg;

  conv_pool_flatten_if #(.AW(AW), .DW(DW)) mif ();

  conv_pool_flatten #(.DW(DW), .IMG_W(64), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem       (mif),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // memories: layer-0 read combinationally, layer-1/2 written by the monitor
  logic [DW-1:0] l0  [2][4096];
  logic [DW-1:0] l1m [2][1024];
  logic [DW-1:0] l2m [2048];
  logic          mem_clr = 1'b0;
  int            proto_err = 0;
  int            max_rd = 0;

  assign mif.cdata_rd = (mif.csel == CSEL_L0K1) ? l0[1][mif.caddr_rd] : l0[0][mif.caddr_rd];

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 1024; i++) l1m[k][i] = SENT;
      for (int j = 0; j < 2048; j++) l2m[j] = SENT;
      max_rd = 0;
    end else begin
      if (mif.crd) begin
        if (int'(mif.caddr_rd) > max_rd) max_rd = int'(mif.caddr_rd);
        if (mif.cwr) proto_err++;
        if (mif.csel != CSEL_L0K0 && mif.csel != CSEL_L0K1) proto_err++;
      end
      if (mif.cwr) begin
        case (mif.csel)
          CSEL_L1K0: if (mif.caddr_wr > 1023) proto_err++; else l1m[0][mif.caddr_wr[9:0]] = mif.cdata_wr;
          CSEL_L1K1: if (mif.caddr_wr > 1023) proto_err++; else l1m[1][mif.caddr_wr[9:0]] = mif.cdata_wr;
`ifdef CONV_FLATTEN_EN
          CSEL_L2:   if (mif.caddr_wr > 2047) proto_err++; else l2m[mif.caddr_wr[10:0]] = mif.cdata_wr;
`endif
          default:   proto_err++;
        endcase
      end
    end
  end

  // scoreboard
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: max over the 2x2 window straight from the index arithmetic
  function automatic logic [DW-1:0] gold_l1(int k, int i);
    int r = i / 32;
    int c = i % 32;
    logic [DW-1:0] m = '0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        if (l0[k][(2*r+dy)*64 + 2*c + dx] > m) m = l0[k][(2*r+dy)*64 + 2*c + dx];
    return m;
  endfunction

  task automatic check_model(input string tag);
    int bad = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1024; i++)
        if (l1m[k][i] !== gold_l1(k, i)) bad++;
`ifdef CONV_FLATTEN_EN
    for (int j = 0; j < 2048; j++)
      if (l2m[j] !== gold_l1(j % 2, j / 2)) bad++;
`endif
    check({tag, "_model_mismatches"}, bad, 0);
  endtask

  typedef struct {
    int            run;
    int            mem;   // 0/1 = L1 kernel, 2 = L2
    int            idx;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs [NV];

  function automatic logic [DW-1:0] tb_mem(int m, int idx);
    if (m == 2) return l2m[idx];
    return l1m[m][idx];
  endfunction

  task automatic apply_table(input int run);
    for (int v = 0; v < NV; v++)
      if (vecs[v].run == run)
        check($sformatf("tbl%0d_run%0d_m%0d[%0d]", v, run, vecs[v].mem, vecs[v].idx),
              tb_mem(vecs[v].mem, vecs[v].idx), vecs[v].exp);
  endtask

  task automatic fill_zero();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 4096; a++) l0[k][a] = '0;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 4096; a++) l0[k][a] = DW'($urandom);
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    mem_clr = 1'b0;
    @(negedge clk);
  endtask

  // start one job and follow it to done; optionally re-pulse start mid-run
  task automatic do_run(input string tag, input int retrigger_at);
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic seen = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen && cyc < 20000) begin
      if (busy) busy_cnt++;
      if (done) begin seen = 1'b1; done_cnt++; end
      start = (retrigger_at > 0 && busy && busy_cnt == retrigger_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_cycles"}, busy_cnt, BUSY_EXP);
    check({tag, "_done_width"}, done_cnt, 1);
    check({tag, "_idle_after"}, state_dbg, S_IDLE);
  endtask

  initial begin
    vecs[0] = '{0, 0, 0,    20'h00005};
    vecs[1] = '{0, 1, 0,    20'h00005};
    vecs[2] = '{0, 1, 1023, 20'hFFFFF};
    vecs[3] = '{0, 0, 1,    20'h00000};
    vecs[4] = '{1, 0, 0,    20'h00123};
    vecs[5] = '{1, 0, 1,    20'h00000};
    vecs[6] = '{1, 1, 0,    20'h00000};
    vecs[7] = '{1, 0, 1023, 20'h00000};
`ifdef CONV_FLATTEN_EN
    vecs[8] = '{0, 2, 2047, 20'hFFFFF};
    vecs[9] = '{0, 2, 1,    20'h00005};
`endif

    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_crd", mif.crd, 0);
    check("rst_cwr", mif.cwr, 0);
    check("rst_csel", mif.csel, 0);
    check("rst_caddr_rd", mif.caddr_rd, 0);
    check("rst_caddr_wr", mif.caddr_wr, 0);
    check("rst_cdata_wr", mif.cdata_wr, 0);
    reset = 1'b1;
    @(negedge clk);

    // run 0: first-read load in window 0 of both kernels, corner pixel of k1
    fill_zero();
    l0[0][0] = 20'h00005; l0[0][1] = 20'h00003; l0[0][64] = 20'h00002; l0[0][65] = 20'h00001;
    l0[1][0] = 20'h00001; l0[1][1] = 20'h00003; l0[1][64] = 20'h00002; l0[1][65] = 20'h00005;
    l0[1][4095] = 20'hFFFFF;
    clear_mem();
    do_run("run0", 0);
    check("run0_max_caddr_rd", max_rd, 4095);
    check_model("run0");
    apply_table(0);

    // run 1: single non-zero pixel in the bottom-right of window 0
    fill_zero();
    l0[0][65] = 20'h00123;
    clear_mem();
    do_run("run1", 0);
    check_model("run1");
    apply_table(1);

    // run 2: random maps with a start re-pulse 50 cycles into busy
    fill_rand();
    clear_mem();
    do_run("run2", 50);
    check_model("run2");

    // run 3: reset dropped at busy cycle 100, then a full restart
    fill_rand();
    clear_mem();
    begin
      int n = 0;
      int guard = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (n < 100 && guard < 1000) begin
        if (busy) n++;
        guard++;
        if (n < 100) @(negedge clk);
      end
      check("abort_reached_100", n, 100);
    end
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_crd", mif.crd, 0);
    check("abort_cwr", mif.cwr, 0);
    check("abort_state", state_dbg, S_IDLE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_mem();
    do_run("run3", 0);
    check_model("run3");

    check("protocol_errors", proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
